dimm_err_inj: RTL and testbench

Parametrised, clocked DRAM write-path error injector for the manycore DIMM model. It sits between the memory controller's DQ/CB pins and the DIMM behavioural model. It decodes WRITE commands on a selected chip-select and queues them, so back-to-back writes are tracked. After a programmable write latency it corrupts chosen beats of each burst according to a runtime mode: single-nibble data, ECC, multi-nibble, address-parity or fail-over. All randomness comes from a seeded LFSR, so failing seeds reproduce.

---
 rtl/dimm_err_pkg.sv | 12 +
 rtl/dimm_err_lfsr.sv | 16 +
 rtl/dimm_err_inj.sv | 148 ++++++++++++++
 tb/tb_dimm_err_inj.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dimm_err_pkg.sv
// dimm_err_pkg: modes, LFSR taps and burst state shared by the DIMM write-path error injector
package dimm_err_pkg;
    typedef enum logic [2:0] {
        MODE_OFF, MODE_SECC_DATA, MODE_SECC_ECC, MODE_RANDOM,
        MODE_MECC, MODE_ADDR_PAR, MODE_FAILOVER, MODE_FAILOVER_SECC
    } mode_e;
    typedef enum logic {BURST_IDLE, BURST_RUN} burst_e;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? (s >> 1) ^ LFSR_TAPS : s >> 1;
    endfunction
endpackage

// File: rtl/dimm_err_lfsr.sv
// dimm_err_lfsr: 32-bit Galois LFSR, seeded on reset, advanced one step per enable
module dimm_err_lfsr
    import dimm_err_pkg::*;
(
    input  logic        clk,
    input  logic        DRAM_RST_L,
    input  logic [31:0] seed,
    input  logic        adv,
    output logic [31:0] nxt
);
    logic [31:0] state;
    assign nxt = lfsr_step(state);
    always_ff @(posedge clk or posedge DRAM_RST_L)
        if (DRAM_RST_L) state <= seed == '0 ? 32'h1 : seed;
        else if (adv) state <= nxt;
endmodule

// File: rtl/dimm_err_inj.sv
// dimm_err_inj: delays selected-CS WRITEs through a target queue and corrupts chosen burst beats
module dimm_err_inj
    import dimm_err_pkg::*;
#(
    parameter int DQ_W      = 128,
    parameter int CB_W      = 16,
    parameter int NUM_CS    = 2,
    parameter int BURST_LEN = 4,
    parameter int Q_DEPTH   = 4,
    parameter int LAT_W     = 5,
    localparam int CS_W     = NUM_CS > 1 ? $clog2(NUM_CS) : 1,
    localparam int NIB      = $clog2(DQ_W / 4)
) (
    input  logic                 clk,
    input  logic                 DRAM_RST_L,
    input  logic [NUM_CS-1:0]    cs_l,
    input  logic                 ras_l,
    input  logic                 cas_l,
    input  logic                 we_l,
    input  logic [DQ_W-1:0]      dq_in,
    input  logic [CB_W-1:0]      cb_in,
    output logic [DQ_W-1:0]      dq_out,
    output logic [CB_W-1:0]      cb_out,
    input  logic                 cfg_enable,
    input  logic [2:0]           cfg_mode,
    input  logic [CS_W-1:0]      cfg_cs_sel,
    input  logic [LAT_W-1:0]     cfg_lat,
    input  logic [BURST_LEN-1:0] cfg_beat_mask,
    input  logic [NIB-1:0]       cfg_fail_part,
    input  logic                 cfg_one_shot,
    input  logic [31:0]          cfg_seed,
    output logic                 inj_active,
    output logic [15:0]          inj_count,
    output logic                 q_overflow
);
    localparam int BW  = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam int PW  = Q_DEPTH > 1 ? $clog2(Q_DEPTH) : 1;
    localparam int CW  = $clog2(Q_DEPTH + 1);
    localparam int NCB = CB_W / 4;

    logic [LAT_W-1:0] tick, tick_nx, new_tgt;
    logic [LAT_W-1:0] q_tgt [Q_DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    q_cnt;
    logic             q_empty, q_full, done, wr_cmd, head_hit, byp_hit, start, push, drop;
    logic [31:0]      lf_nx;
    logic             unused_lf;
    logic [3:0]       err_bits;
    logic [NIB-1:0]   pos, pos1;
    logic [DQ_W-1:0]  d_single, d_second, d_fail, dq_pat_nx, dq_pat;
    logic [CB_W-1:0]  c_single, cb_pat_nx, cb_pat;
    logic [BURST_LEN-1:0] beat_en;
    logic [BW-1:0]    beat;
    mode_e            mode_eff;
    burst_e           state;

    assign tick_nx = tick + LAT_W'(1);
    assign new_tgt = tick + cfg_lat;
    assign q_empty = q_cnt == '0;
    assign q_full  = q_cnt == CW'(Q_DEPTH);
    assign wr_cmd  = ras_l && !cas_l && !we_l && !cs_l[cfg_cs_sel] && cfg_enable && !done;
    // Bursts launch one edge early so beat 0 lands on the target tick; an empty queue lets a latency-1 WRITE fall through.
    assign head_hit = !q_empty && q_tgt[rd_ptr] == tick_nx;
    assign byp_hit  = q_empty && wr_cmd && new_tgt == tick_nx;
    assign start    = head_hit || byp_hit;
    assign push     = wr_cmd && !byp_hit && (!q_full || head_hit);
    assign drop     = wr_cmd && !byp_hit && q_full && !head_hit;

    always_ff @(posedge clk or posedge DRAM_RST_L)
        if (DRAM_RST_L) begin
            tick       <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            q_cnt      <= '0;
            q_overflow <= 1'b0;
        end else begin
            tick <= tick_nx;
            if (push) wr_ptr <= wr_ptr == PW'(Q_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            if (head_hit) rd_ptr <= rd_ptr == PW'(Q_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            q_cnt <= q_cnt + CW'(push) - CW'(head_hit);
            if (drop) q_overflow <= 1'b1;
        end

    always_ff @(posedge clk)
        if (push) q_tgt[wr_ptr] <= new_tgt;

    dimm_err_lfsr u_lfsr (
        .clk        (clk),
        .DRAM_RST_L (DRAM_RST_L),
        .seed       (cfg_seed),
        .adv        (start),
        .nxt        (lf_nx)
    );

    assign unused_lf = ^lf_nx[26:2*NIB];

    always_comb begin
        err_bits  = lf_nx[31:28] == 4'h0 ? 4'h1 : lf_nx[31:28];
        pos       = lf_nx[NIB-1:0];
        pos1      = lf_nx[2*NIB-1:NIB] == pos ? pos + NIB'(1) : lf_nx[2*NIB-1:NIB];
        mode_eff  = cfg_mode == MODE_RANDOM ? (lf_nx[27] ? MODE_SECC_ECC : MODE_SECC_DATA) : mode_e'(cfg_mode);
        d_single  = DQ_W'(err_bits) << {pos, 2'b00};
        d_second  = DQ_W'(err_bits) << {pos1, 2'b00};
        d_fail    = DQ_W'(4'hF) << {cfg_fail_part, 2'b00};
        c_single  = CB_W'(err_bits) << (4 * (int'(pos) % NCB));
        dq_pat_nx = mode_eff == MODE_SECC_DATA     ? d_single :
                    mode_eff == MODE_MECC          ? d_single | d_second :
                    mode_eff == MODE_FAILOVER      ? d_fail :
                    mode_eff == MODE_FAILOVER_SECC ? d_fail ^ d_single : '0;
        cb_pat_nx = mode_eff == MODE_SECC_ECC ? c_single :
                    mode_eff == MODE_ADDR_PAR ? '1 : '0;
    end

    always_ff @(posedge clk or posedge DRAM_RST_L)
        if (DRAM_RST_L) begin
            state      <= BURST_IDLE;
            beat       <= '0;
            beat_en    <= '0;
            dq_pat     <= '0;
            cb_pat     <= '0;
            inj_active <= 1'b0;
            inj_count  <= '0;
            done       <= 1'b0;
        end else begin
            if (start) begin
                state      <= BURST_RUN;
                beat       <= '0;
                beat_en    <= mode_eff == MODE_OFF ? '0 : cfg_beat_mask;
                dq_pat     <= dq_pat_nx;
                cb_pat     <= cb_pat_nx;
                inj_active <= mode_eff != MODE_OFF && cfg_beat_mask[0];
                if (mode_eff != MODE_OFF && inj_count != 16'hFFFF) inj_count <= inj_count + 16'd1;
            end else if (state == BURST_RUN) begin
                if (beat == BW'(BURST_LEN - 1)) begin
                    state      <= BURST_IDLE;
                    inj_active <= 1'b0;
                end else begin
                    beat       <= beat + BW'(1);
                    inj_active <= beat_en[beat + BW'(1)];
                end
            end
            if (!cfg_enable) done <= 1'b0;
            else if (start && mode_eff != MODE_OFF && cfg_one_shot) done <= 1'b1;
        end

    assign dq_out = inj_active ? dq_in ^ dq_pat : dq_in;
    assign cb_out = inj_active ? cb_in ^ cb_pat : cb_in;
endmodule

// File: tb/tb_dimm_err_inj.sv
// tb_dimm_err_inj: scoreboard bench with hand-computed corrupted beats for dimm_err_inj
module tb_dimm_err_inj;
    logic         clk = 1'b0;
    logic         DRAM_RST_L = 1'b1;
    logic [1:0]   cs_l = 2'b11;
    logic         ras_l = 1'b1, cas_l = 1'b1, we_l = 1'b1;
    logic [127:0] dq_in = '0, dq_out;
    logic [15:0]  cb_in = '0, cb_out;
    logic         cfg_enable = 1'b1;
    logic [2:0]   cfg_mode = 3'd0;
    logic         cfg_cs_sel = 1'b0;
    logic [4:0]   cfg_lat = 5'd5;
    logic [3:0]   cfg_beat_mask = 4'b0001;
    logic [4:0]   cfg_fail_part = 5'd0;
    logic         cfg_one_shot = 1'b0;
    logic [31:0]  cfg_seed = 32'h1;
    logic         inj_active, q_overflow;
    logic [15:0]  inj_count;
    int           cyc = 0, checks = 0, errors = 0, t;
    typedef struct { int cyc; logic [127:0] dq_x; logic [15:0] cb_x; } beat_t;
    beat_t exp_q[$];
    beat_t mon_e;

    dimm_err_inj dut (
        .clk(clk), .DRAM_RST_L(DRAM_RST_L), .cs_l(cs_l), .ras_l(ras_l), .cas_l(cas_l), .we_l(we_l),
        .dq_in(dq_in), .cb_in(cb_in), .dq_out(dq_out), .cb_out(cb_out),
        .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_cs_sel(cfg_cs_sel), .cfg_lat(cfg_lat),
        .cfg_beat_mask(cfg_beat_mask), .cfg_fail_part(cfg_fail_part), .cfg_one_shot(cfg_one_shot),
        .cfg_seed(cfg_seed), .inj_active(inj_active), .inj_count(inj_count), .q_overflow(q_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= DRAM_RST_L ? 0 : cyc + 1;

    always @(posedge clk) begin
        #2;
        dq_in = {$urandom, $urandom, $urandom, $urandom};
        cb_in = 16'($urandom);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_cmd(input logic [1:0] cs);
        cs_l = cs; ras_l = 1'b1; cas_l = 1'b0; we_l = 1'b0;
        step();
        cs_l = 2'b11; ras_l = 1'b1; cas_l = 1'b1; we_l = 1'b1;
    endtask

    task automatic expect_burst(input int t0, input logic [3:0] mask, input logic [127:0] dx, input logic [15:0] cx);
        for (int b = 0; b < 4; b++)
            if (mask[b]) exp_q.push_back('{t0 + b, dx, cx});
    endtask

    task automatic do_reset();
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        DRAM_RST_L = 1'b1;
        step(2);
        DRAM_RST_L = 1'b0;
        chk("rst_inj_count", 128'(inj_count), 128'd0);
        chk("rst_overflow", 128'(q_overflow), 128'd0);
        chk("rst_inj_active", 128'(inj_active), 128'd0);
        chk("rst_passthru", dq_out ^ dq_in, 128'd0);
    endtask

    // Monitor: every corrupted beat must match the head of the scoreboard; all other cycles pass through.
    always @(negedge clk) if (!DRAM_RST_L) begin
        if (inj_active) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat cycle=%0d dq_diff=%0h cb_diff=%0h", cyc, dq_out ^ dq_in, cb_out ^ cb_in);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_cycle", 128'(cyc), 128'(mon_e.cyc));
                chk("beat_dq_diff", dq_out ^ dq_in, mon_e.dq_x);
                chk("beat_cb_diff", 128'(cb_out ^ cb_in), 128'(mon_e.cb_x));
            end
        end else begin
            chk("passthru_dq", dq_out, dq_in);
            chk("passthru_cb", 128'(cb_out), 128'(cb_in));
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_beat cycle=%0d required_cycle=%0d", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        // Single-nibble data error: seed 1 -> first pattern err 8 at nibble 3
        cfg_mode = 3'd1; cfg_lat = 5'd5; cfg_beat_mask = 4'b0001;
        do_reset();
        step(9);
        t = cyc;
        expect_burst(t + 5, 4'b0001, 128'h8000, 16'h0);
        write_cmd(2'b10);
        step(10);
        chk("t1_inj_count", 128'(inj_count), 128'd1);
        // Address parity on all beats; wrong CS ignored; disabling after the WRITE keeps the entry
        cfg_mode = 3'd5; cfg_beat_mask = 4'b1111; cfg_lat = 5'd3; cfg_cs_sel = 1'b1;
        do_reset();
        write_cmd(2'b10);
        step(6);
        t = cyc;
        expect_burst(t + 3, 4'b1111, 128'h0, 16'hFFFF);
        write_cmd(2'b01);
        cfg_enable = 1'b0;
        step(10);
        chk("t2_inj_count", 128'(inj_count), 128'd1);
        cfg_enable = 1'b1; cfg_cs_sel = 1'b0;
        // Fail-over on nibble 3, alternate beats
        cfg_mode = 3'd6; cfg_fail_part = 5'd3; cfg_beat_mask = 4'b0101; cfg_lat = 5'd4;
        do_reset();
        t = cyc;
        expect_burst(t + 4, 4'b0101, 128'h0000F000, 16'h0);
        write_cmd(2'b10);
        step(10);
        chk("t3_inj_count", 128'(inj_count), 128'd1);
        // Five back-to-back WRITEs into a 4-deep queue; seed 0 behaves as seed 1; each target restarts the burst
        cfg_mode = 3'd1; cfg_beat_mask = 4'b0001; cfg_lat = 5'd10; cfg_seed = 32'h0;
        do_reset();
        t = cyc;
        expect_burst(t + 10, 4'b0001, 128'h8000, 16'h0);
        expect_burst(t + 11, 4'b0001, 128'h0C00, 16'h0);
        expect_burst(t + 12, 4'b0001, 128'h0060, 16'h0);
        expect_burst(t + 13, 4'b0001, 128'hB000, 16'h0);
        repeat (5) write_cmd(2'b10);
        chk("t4_overflow_early", 128'(q_overflow), 128'd1);
        step(15);
        chk("t4_inj_count", 128'(inj_count), 128'd4);
        chk("t4_overflow_sticky", 128'(q_overflow), 128'd1);
        cfg_seed = 32'h1;
        // One-shot on ECC nibble; second WRITE ignored until enable toggles
        cfg_mode = 3'd2; cfg_beat_mask = 4'b0010; cfg_lat = 5'd3; cfg_one_shot = 1'b1;
        do_reset();
        t = cyc;
        expect_burst(t + 3, 4'b0010, 128'h0, 16'h8000);
        write_cmd(2'b10);
        step(6);
        write_cmd(2'b10);
        step(6);
        chk("t5_oneshot_count", 128'(inj_count), 128'd1);
        cfg_enable = 1'b0;
        step();
        cfg_enable = 1'b1;
        t = cyc;
        expect_burst(t + 3, 4'b0010, 128'h0, 16'h0C00);
        write_cmd(2'b10);
        step(8);
        chk("t5_rearm_count", 128'(inj_count), 128'd2);
        cfg_one_shot = 1'b0;
        // Mode 0 burns a pattern without counting; then fail-over XOR single-nibble
        cfg_mode = 3'd0; cfg_beat_mask = 4'b1111; cfg_lat = 5'd3; cfg_fail_part = 5'd1;
        do_reset();
        write_cmd(2'b10);
        step(5);
        chk("t6_off_count", 128'(inj_count), 128'd0);
        cfg_mode = 3'd7; cfg_beat_mask = 4'b1000;
        t = cyc;
        expect_burst(t + 3, 4'b1000, 128'h0CF0, 16'h0);
        write_cmd(2'b10);
        step(8);
        chk("t6_inj_count", 128'(inj_count), 128'd1);
        // Multi-nibble burst cut by reset at beat 2
        cfg_mode = 3'd4; cfg_beat_mask = 4'b1111; cfg_lat = 5'd2;
        do_reset();
        t = cyc;
        expect_burst(t + 2, 4'b0011, 128'h8008, 16'h0);
        write_cmd(2'b10);
        step(3);
        chk("t7_beat2_active", 128'(inj_active), 128'd1);
        #2;
        DRAM_RST_L = 1'b1;
        #1;
        chk("t7_rst_inj_active", 128'(inj_active), 128'd0);
        chk("t7_rst_passthru_dq", dq_out, dq_in);
        chk("t7_rst_passthru_cb", 128'(cb_out), 128'(cb_in));
        do_reset();
        step(4);
        chk("final_queue_drained", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
